decoder_seq: RTL and testbench

Registered, parametrised IN_W-to-2^IN_W one-hot decoder with a built-in scan sequencer. In direct mode it latches a binary index on a load strobe and drives the matching one-hot line. In scan mode it walks the active line up or down at a programmable rate, with wrap-around and a wrap pulse. It sits between the control logic and any downstream row/select/strobe fan-out that needs glitch-free, registered select lines.

---
 rtl/decoder_pkg.sv | 19 +
 rtl/onehot_dec.sv | 16 +
 rtl/decoder_seq.sv | 112 +++++++++++
 tb/tb_decoder_seq.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decoder_pkg.sv
// Shared definitions for the decoder_seq block.
//   state_e     : FSM state encoding (IDLE/DIRECT/SCAN)
//   MODE_*      : values of the mode input
//   DIR_*       : values of the scan direction input
package decoder_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2
  } state_e;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/onehot_dec.sv
// Purely combinational binary to one-hot converter.
//   bin_i    : binary index, IN_W bits
//   onehot_o : 2^IN_W-bit vector with exactly bit[bin_i] set
module onehot_dec #(
  parameter int unsigned IN_W = 3
) (
  input  logic [IN_W-1:0]      bin_i,
  output logic [(2**IN_W)-1:0] onehot_o
);

  always_comb begin
    onehot_o        = '0;
    onehot_o[bin_i] = 1'b1;
  end

endmodule

// File: rtl/decoder_seq.sv
// Registered one-hot decoder with a built-in scan sequencer.
//   clka  : clock, rising edge
//   rst_n : asynchronous active-low reset
//   E     : block enable, 0 forces outputs low (IDLE)
//   mode  : 0 = direct (load/hold), 1 = scan
//   load  : one-cycle strobe capturing In as the new index
//   In    : binary index to capture
//   div   : scan step period minus one, in cycles
//   dir   : scan direction, 0 = up, 1 = down
//   Out   : registered one-hot select, zero when idle
//   idx   : registered current index
//   wrap  : one-cycle pulse coincident with a scan wrap-around
module decoder_seq
  import decoder_pkg::*;
#(
  parameter int unsigned IN_W  = 3,
  parameter int unsigned DIV_W = 8
) (
  input  logic                 clka,
  input  logic                 rst_n,
  input  logic                 E,
  input  logic                 mode,
  input  logic                 load,
  input  logic [IN_W-1:0]      In,
  input  logic [DIV_W-1:0]     div,
  input  logic                 dir,
  output logic [(2**IN_W)-1:0] Out,
  output logic [IN_W-1:0]      idx,
  output logic                 wrap
);

  localparam int unsigned OUT_W = 2**IN_W;

  state_e             state_q, state_d;
  logic [IN_W-1:0]    idx_q,   idx_d;
  logic [DIV_W-1:0]   psc_q,   psc_d;
  logic               wrap_q,  wrap_d;
  logic [OUT_W-1:0]   out_q,   out_d;
  logic [OUT_W-1:0]   dec_onehot;

  // Next state is resolved first so that the edge which enters a state
  // already applies that state's behaviour (e.g. E rising with load high
  // captures In immediately).
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    psc_d   = psc_q;
    wrap_d  = 1'b0;

    if (!E) begin
      state_d = IDLE;
    end else begin
      state_d = (mode == MODE_SCAN) ? SCAN : DIRECT;

      if (load) begin
        idx_d = In;
        if (state_d == SCAN) begin
          psc_d = '0;
        end
      end else if (state_d == SCAN) begin
        if (state_q != SCAN) begin
          // Entry into scan restarts the step period without stepping.
          psc_d = '0;
        end else if (psc_q == div) begin
          psc_d = '0;
          if (dir == DIR_UP) begin
            idx_d  = idx_q + 1'b1;
            wrap_d = (idx_q == '1);
          end else begin
            idx_d  = idx_q - 1'b1;
            wrap_d = (idx_q == '0);
          end
        end else begin
          psc_d = psc_q + 1'b1;
        end
      end
    end
  end

  // Decoding the next index keeps Out aligned with idx in the same cycle.
  onehot_dec #(
    .IN_W (IN_W)
  ) u_dec (
    .bin_i    (idx_d),
    .onehot_o (dec_onehot)
  );

  always_comb begin
    out_d = (state_d == IDLE) ? '0 : dec_onehot;
  end

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      psc_q   <= '0;
      wrap_q  <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      psc_q   <= psc_d;
      wrap_q  <= wrap_d;
      out_q   <= out_d;
    end
  end

  assign Out  = out_q;
  assign idx  = idx_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_decoder_seq.sv
// Self-checking bench for decoder_seq: an 8-line instance exercises the
// direct, enable, scan and collision behaviour, and a 16-line instance
// exercises asynchronous reset in the middle of a scan.
module tb_decoder_seq;

  typedef struct packed {
    logic [7:0] o;
    logic [2:0] i;
    logic       w;
  } exp8_t;

  typedef struct packed {
    logic [15:0] o;
    logic [3:0]  i;
    logic        w;
  } exp16_t;

  logic clk;
  int   checks;
  int   failures;

  exp8_t  q8[$];
  exp16_t q16[$];

  // 8-line instance
  logic       rst_n, E, mode, load, dir;
  logic [2:0] In;
  logic [7:0] div;
  logic [7:0] Out;
  logic [2:0] idx;
  logic       wrap;

  // 16-line instance
  logic        rst2_n, E2, mode2, load2, dir2;
  logic [3:0]  In2;
  logic [7:0]  div2;
  logic [15:0] Out2;
  logic [3:0]  idx2;
  logic        wrap2;

  decoder_seq #(
    .IN_W  (3),
    .DIV_W (8)
  ) dut (
    .clka  (clk),
    .rst_n (rst_n),
    .E     (E),
    .mode  (mode),
    .load  (load),
    .In    (In),
    .div   (div),
    .dir   (dir),
    .Out   (Out),
    .idx   (idx),
    .wrap  (wrap)
  );

  decoder_seq #(
    .IN_W  (4),
    .DIV_W (8)
  ) dut16 (
    .clka  (clk),
    .rst_n (rst2_n),
    .E     (E2),
    .mode  (mode2),
    .load  (load2),
    .In    (In2),
    .div   (div2),
    .dir   (dir2),
    .Out   (Out2),
    .idx   (idx2),
    .wrap  (wrap2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp8_t e;
    rst_n = 1'b0; E = 1'b1; mode = 1'b0; load = 1'b0;
    In = '0; div = '0; dir = 1'b0;
    q8.push_back('{o: 8'h00, i: 3'd0, w: 1'b0});
    cyc();
    cyc();
    e = q8.pop_front();
    checks++;
    if ({Out, idx, wrap} !== e) begin
      failures++;
      $display("FAIL reset_hold: got Out=%h idx=%0d wrap=%b, want Out=%h idx=%0d wrap=%b",
               Out, idx, wrap, e.o, e.i, e.w);
    end
    rst_n = 1'b1;
    q8.push_back('{o: 8'h01, i: 3'd0, w: 1'b0});
    cyc();
    e = q8.pop_front();
    checks++;
    if ({Out, idx, wrap} !== e) begin
      failures++;
      $display("FAIL reset_release: got Out=%h idx=%0d wrap=%b, want Out=%h idx=%0d wrap=%b",
               Out, idx, wrap, e.o, e.i, e.w);
    end
  endtask

  task automatic test_direct_load();
    exp8_t      e;
    logic [7:0] one;
    one = 8'h01;
    for (int i = 0; i < 8; i++) begin
      In   = 3'(i);
      load = 1'b1;
      q8.push_back('{o: one << i, i: 3'(i), w: 1'b0});
      cyc();
      load = 1'b0;
      e = q8.pop_front();
      checks++;
      if ({Out, idx, wrap} !== e) begin
        failures++;
        $display("FAIL direct_load[%0d]: got Out=%h idx=%0d wrap=%b, want Out=%h idx=%0d wrap=%b",
                 i, Out, idx, wrap, e.o, e.i, e.w);
      end
    end
    // hold cycle, then E low, then load ignored while idle
    q8.push_back('{o: 8'h80, i: 3'd7, w: 1'b0});
    q8.push_back('{o: 8'h00, i: 3'd7, w: 1'b0});
    q8.push_back('{o: 8'h00, i: 3'd7, w: 1'b0});
    for (int k = 0; k < 3; k++) begin
      if (k == 1) E = 1'b0;
      if (k == 2) begin load = 1'b1; In = 3'd3; end
      cyc();
      load = 1'b0;
      e = q8.pop_front();
      checks++;
      if ({Out, idx, wrap} !== e) begin
        failures++;
        $display("FAIL direct_hold_idle[%0d]: got Out=%h idx=%0d wrap=%b, want Out=%h idx=%0d wrap=%b",
                 k, Out, idx, wrap, e.o, e.i, e.w);
      end
    end
  endtask

  task automatic test_enable();
    exp8_t e;
    // E rising with load, E falling, E rising without load
    q8.push_back('{o: 8'h08, i: 3'd3, w: 1'b0});
    q8.push_back('{o: 8'h00, i: 3'd3, w: 1'b0});
    q8.push_back('{o: 8'h08, i: 3'd3, w: 1'b0});
    for (int k = 0; k < 3; k++) begin
      E    = (k != 1);
      mode = 1'b0;
      load = (k == 0);
      In   = 3'd3;
      cyc();
      load = 1'b0;
      e = q8.pop_front();
      checks++;
      if ({Out, idx, wrap} !== e) begin
        failures++;
        $display("FAIL enable[%0d]: got Out=%h idx=%0d wrap=%b, want Out=%h idx=%0d wrap=%b",
                 k, Out, idx, wrap, e.o, e.i, e.w);
      end
    end
  endtask

  task automatic test_scan_up();
    exp8_t e;
    exp8_t tbl [9];
    // load 6 in direct, entry edge, then steps every 3 cycles
    tbl = '{'{8'h40, 3'd6, 1'b0}, '{8'h40, 3'd6, 1'b0},
            '{8'h40, 3'd6, 1'b0}, '{8'h40, 3'd6, 1'b0},
            '{8'h80, 3'd7, 1'b0}, '{8'h80, 3'd7, 1'b0},
            '{8'h80, 3'd7, 1'b0}, '{8'h01, 3'd0, 1'b1},
            '{8'h01, 3'd0, 1'b0}};
    E = 1'b1; mode = 1'b0; div = 8'd2; dir = 1'b0;
    for (int k = 0; k < 9; k++) begin
      load = (k == 0);
      In   = 3'd6;
      mode = (k != 0);
      q8.push_back(tbl[k]);
      cyc();
      load = 1'b0;
      e = q8.pop_front();
      checks++;
      if ({Out, idx, wrap} !== e) begin
        failures++;
        $display("FAIL scan_up[%0d]: got Out=%h idx=%0d wrap=%b, want Out=%h idx=%0d wrap=%b",
                 k, Out, idx, wrap, e.o, e.i, e.w);
      end
    end
  endtask

  task automatic test_scan_down();
    exp8_t e;
    exp8_t tbl [5];
    tbl = '{'{8'h02, 3'd1, 1'b0}, '{8'h02, 3'd1, 1'b0},
            '{8'h01, 3'd0, 1'b0}, '{8'h80, 3'd7, 1'b1},
            '{8'h40, 3'd6, 1'b0}};
    div = 8'd0; dir = 1'b1;
    for (int k = 0; k < 5; k++) begin
      load = (k == 0);
      In   = 3'd1;
      mode = (k != 0);
      q8.push_back(tbl[k]);
      cyc();
      load = 1'b0;
      e = q8.pop_front();
      checks++;
      if ({Out, idx, wrap} !== e) begin
        failures++;
        $display("FAIL scan_down[%0d]: got Out=%h idx=%0d wrap=%b, want Out=%h idx=%0d wrap=%b",
                 k, Out, idx, wrap, e.o, e.i, e.w);
      end
    end
  endtask

  task automatic test_collision();
    exp8_t e;
    exp8_t tbl [4];
    // up from 6: step to 7, then load 5 on the edge that would wrap
    tbl = '{'{8'h80, 3'd7, 1'b0}, '{8'h20, 3'd5, 1'b0},
            '{8'h40, 3'd6, 1'b0}, '{8'h80, 3'd7, 1'b0}};
    mode = 1'b1; div = 8'd0; dir = 1'b0;
    for (int k = 0; k < 4; k++) begin
      load = (k == 1);
      In   = 3'd5;
      q8.push_back(tbl[k]);
      cyc();
      load = 1'b0;
      e = q8.pop_front();
      checks++;
      if ({Out, idx, wrap} !== e) begin
        failures++;
        $display("FAIL collision[%0d]: got Out=%h idx=%0d wrap=%b, want Out=%h idx=%0d wrap=%b",
                 k, Out, idx, wrap, e.o, e.i, e.w);
      end
    end
  endtask

  task automatic test_async_reset();
    exp16_t e;
    exp16_t pre  [4];
    exp16_t post [3];
    pre  = '{'{16'h0200, 4'd9, 1'b0}, '{16'h0200, 4'd9, 1'b0},
             '{16'h0400, 4'd10, 1'b0}, '{16'h0800, 4'd11, 1'b0}};
    post = '{'{16'h0001, 4'd0, 1'b0}, '{16'h0002, 4'd1, 1'b0},
             '{16'h0004, 4'd2, 1'b0}};
    rst2_n = 1'b1; E2 = 1'b1; div2 = 8'd0; dir2 = 1'b0; In2 = 4'd9;
    for (int k = 0; k < 4; k++) begin
      load2 = (k == 0);
      mode2 = (k != 0);
      q16.push_back(pre[k]);
      cyc();
      load2 = 1'b0;
      e = q16.pop_front();
      checks++;
      if ({Out2, idx2, wrap2} !== e) begin
        failures++;
        $display("FAIL async_prescan[%0d]: got Out=%h idx=%0d wrap=%b, want Out=%h idx=%0d wrap=%b",
                 k, Out2, idx2, wrap2, e.o, e.i, e.w);
      end
    end
    // reset between edges must clear without a clock
    #3;
    rst2_n = 1'b0;
    q16.push_back('{o: 16'h0000, i: 4'd0, w: 1'b0});
    #1;
    e = q16.pop_front();
    checks++;
    if ({Out2, idx2, wrap2} !== e) begin
      failures++;
      $display("FAIL async_immediate: got Out=%h idx=%0d wrap=%b, want Out=%h idx=%0d wrap=%b",
               Out2, idx2, wrap2, e.o, e.i, e.w);
    end
    cyc();
    rst2_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      q16.push_back(post[k]);
      cyc();
      e = q16.pop_front();
      checks++;
      if ({Out2, idx2, wrap2} !== e) begin
        failures++;
        $display("FAIL async_resume[%0d]: got Out=%h idx=%0d wrap=%b, want Out=%h idx=%0d wrap=%b",
                 k, Out2, idx2, wrap2, e.o, e.i, e.w);
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst2_n = 1'b0; E2 = 1'b0; mode2 = 1'b0; load2 = 1'b0;
    In2 = '0; div2 = '0; dir2 = 1'b0;
    test_reset();
    test_direct_load();
    test_enable();
    test_scan_up();
    test_scan_down();
    test_collision();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
